// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: field layout,
// default geometry, the injected NOP word and the stage occupancy encoding.
package pipe_pkg;

    localparam int PIPE_WIDTH  = 32;
    localparam int PIPE_FIELDS = 4;

    localparam int FIELD_NEWPC  = 0;
    localparam int FIELD_INSTR  = 1;
    localparam int FIELD_ALUOUT = 2;
    localparam int FIELD_MEMOUT = 3;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream valid/ready/data,
// squash, and downstream valid/ready/data. The stage itself uses the slave view.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int WIDTH  = PIPE_WIDTH,
    parameter int FIELDS = PIPE_FIELDS
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH*FIELDS-1:0]   in_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH*FIELDS-1:0]   out_data;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear, updated on the falling
// clock edge like the stage registers it observes.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(negedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and
// flush-to-NOP. Optional stall/bubble counters are built with PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              WIDTH       = PIPE_WIDTH,
    parameter int              FIELDS      = PIPE_FIELDS,
    parameter int              INSTR_FIELD = FIELD_INSTR,
    parameter logic [WIDTH-1:0] NOP_WORD   = pipe_pkg::NOP_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_reg_if.slave      bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
`endif
);
    localparam int DW = WIDTH * FIELDS;

    stage_state_t    state_reg, state_next;
    logic [DW-1:0]   main_reg, main_next;
    logic [DW-1:0]   skid_reg, skid_next;
    logic            in_ready_reg, in_ready_next;
    logic [DW-1:0]   reset_word;
    logic            stage_valid;
    logic            in_xfer;
    logic            out_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < FIELDS; gi++) begin : g_reset_word
            assign reset_word[gi*WIDTH +: WIDTH] = (gi == INSTR_FIELD) ? NOP_WORD : '0;
        end
    endgenerate

    assign stage_valid = (state_reg != ST_EMPTY);
    assign in_xfer     = bus.in_valid && in_ready_reg;
    assign out_xfer    = stage_valid && bus.out_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (bus.flush) begin
            // Squash: drop everything, keep non-instruction fields as they were
            state_next = ST_EMPTY;
            main_next[INSTR_FIELD*WIDTH +: WIDTH] = NOP_WORD;
        end else begin
            unique case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_next  = bus.in_data;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_next = bus.in_data;
                    end else if (in_xfer) begin
                        skid_next  = bus.in_data;
                        state_next = ST_FULL;
                    end else if (out_xfer) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain path is possible
                    if (out_xfer) begin
                        main_next  = skid_reg;
                        state_next = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
        in_ready_next = (state_next != ST_FULL);
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_reg    <= ST_EMPTY;
            main_reg     <= reset_word;
            skid_reg     <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            in_ready_reg <= in_ready_next;
        end
    end

    assign bus.out_valid = stage_valid;
    assign bus.out_data  = main_reg;
    assign bus.in_ready  = in_ready_reg;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stage_valid && !bus.out_ready),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(32)) u_bubble_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (!stage_valid && !rst),
        .count (bubble_cnt)
    );
`endif
endmodule
